// File: rtl/bit_serializer_if.sv
// Handshake and serial-stream bundle for bit_serializer.
// master = upstream word producer / serial consumer side, slave = the serializer itself.
interface bit_serializer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output ser_out,
        output ser_valid,
        output ser_last
    );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-in serial-out stage feeding the sequence detector; frames run back-to-back.
// Define SER_PARITY_EN to append an even-parity bit after each WIDTH-bit data frame.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    bit_serializer_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef SER_PARITY_EN
    localparam int unsigned FRAME = WIDTH + 1;
`else
    localparam int unsigned FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`endif

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_ser_last;
`ifdef SER_PARITY_EN
    logic             r_parity;
    logic             w_parity_d;
`endif

    logic [1:0]       w_state_d;
    logic [CW-1:0]    w_cnt_d;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] w_shift_d;
    logic             w_ser_out_d;
    logic             w_ser_valid_d;
    logic             w_ser_last_d;
    logic             w_ready;
    logic             w_accept;

    // Bit that leaves the word first, in the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // Ready depends on registered state only, never on din_valid.
    assign w_ready   = (r_state == ST_IDLE) || r_ser_last;
    assign w_accept  = bus.din_valid && w_ready;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_shift_d     = r_shift;
        w_ser_out_d   = 1'b0;
        w_ser_valid_d = 1'b0;
        w_ser_last_d  = 1'b0;
`ifdef SER_PARITY_EN
        w_parity_d    = r_parity;
`endif

        if (w_accept) begin
            // First bit goes straight to the output register; the remainder waits in r_shift.
            w_state_d     = ST_SHIFT;
            w_cnt_d       = '0;
            w_shift_d     = shift_one(bus.din);
            w_ser_out_d   = head_bit(bus.din);
            w_ser_valid_d = 1'b1;
            w_ser_last_d  = (FRAME_LAST == '0);
`ifdef SER_PARITY_EN
            w_parity_d    = ^bus.din;
`endif
        end else if (w_ready) begin
            w_state_d = ST_IDLE;
            w_cnt_d   = '0;
`ifdef SER_PARITY_EN
        end else if (r_state == ST_SHIFT && r_cnt == LAST_DATA) begin
            w_state_d     = ST_PARITY;
            w_cnt_d       = w_cnt_inc;
            w_ser_out_d   = r_parity;
            w_ser_valid_d = 1'b1;
            w_ser_last_d  = 1'b1;
`endif
        end else begin
            w_cnt_d       = w_cnt_inc;
            w_shift_d     = shift_one(r_shift);
            w_ser_out_d   = head_bit(r_shift);
            w_ser_valid_d = 1'b1;
            w_ser_last_d  = (w_cnt_inc == FRAME_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_shift     <= w_shift_d;
            r_ser_out   <= w_ser_out_d;
            r_ser_valid <= w_ser_valid_d;
            r_ser_last  <= w_ser_last_d;
`ifdef SER_PARITY_EN
            r_parity    <= w_parity_d;
`endif
        end
    end

    assign bus.din_ready = w_ready;
    assign bus.ser_out   = r_ser_out;
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_last  = r_ser_last;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first and LSB-first instances, WIDTH=8.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic cap_o [0:47];
    logic cap_v [0:47];
    logic cap_l [0:47];
    logic cap_r [0:47];

    bit_serializer_if #(.WIDTH(W)) m_if ();
    bit_serializer_if #(.WIDTH(W)) l_if ();

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (m_if)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (l_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bit on cycle c (1-based) of a frame carrying word w.
    function automatic logic exp_bit(input logic [7:0] w, input int c, input bit msb);
        if (c > W) return ^w;
        return msb ? w[W - c] : w[c - 1];
    endfunction

    task automatic record(input int c, input bit lsb);
        if (lsb) begin
            cap_o[c] = l_if.ser_out;  cap_v[c] = l_if.ser_valid;
            cap_l[c] = l_if.ser_last; cap_r[c] = l_if.din_ready;
        end else begin
            cap_o[c] = m_if.ser_out;  cap_v[c] = m_if.ser_valid;
            cap_l[c] = m_if.ser_last; cap_r[c] = m_if.din_ready;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        m_if.din = 8'h00; m_if.din_valid = 1'b0;
        l_if.din = 8'h00; l_if.din_valid = 1'b0;
        repeat (2) @(negedge clk);
        record(0, 1'b0);
        n_checks++;
        if ({cap_o[0], cap_v[0], cap_l[0], cap_r[0]} !== 4'b0001)
            $display("FAIL reset_state: got out/valid/last/ready=%b expected 0001",
                     {cap_o[0], cap_v[0], cap_l[0], cap_r[0]});
        reset = 1'b0;
        @(negedge clk);
        record(0, 1'b1);
        n_checks++;
        if ({cap_o[0], cap_v[0], cap_l[0], cap_r[0]} !== 4'b0001)
            $display("FAIL idle_after_reset: got %b expected 0001",
                     {cap_o[0], cap_v[0], cap_l[0], cap_r[0]});
    endtask

    task automatic test_single_frame();
        logic [3:0] exp;
        m_if.din = 8'hB0; m_if.din_valid = 1'b1;
        @(negedge clk);
        m_if.din_valid = 1'b0;
        for (int c = 1; c <= F + 2; c++) begin
            record(c, 1'b0);
            @(negedge clk);
        end
        for (int c = 1; c <= F + 2; c++) begin
            exp = {(c <= F) ? exp_bit(8'hB0, c, 1'b1) : 1'b0, c <= F, c == F, c >= F};
            n_checks++;
            if ({cap_o[c], cap_v[c], cap_l[c], cap_r[c]} !== exp) begin
                n_fail++;
                $display("FAIL single_frame cycle %0d: got out/valid/last/ready=%b expected %b",
                         c, {cap_o[c], cap_v[c], cap_l[c], cap_r[c]}, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        logic [7:0] w;
        int         k;
        m_if.din = 8'hB5; m_if.din_valid = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 2 * F + 1; c++) begin
            record(c, 1'b0);
            if (c == 1) m_if.din = 8'h0D;
            if (c == F + 1) m_if.din_valid = 1'b0;
            @(negedge clk);
        end
        for (int c = 1; c <= 2 * F + 1; c++) begin
            w = (c <= F) ? 8'hB5 : 8'h0D;
            k = (c <= F) ? c : c - F;
            exp = {(c <= 2 * F) ? exp_bit(w, k, 1'b1) : 1'b0, c <= 2 * F,
                   c == F || c == 2 * F, c == F || c >= 2 * F};
            n_checks++;
            if ({cap_o[c], cap_v[c], cap_l[c], cap_r[c]} !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got out/valid/last/ready=%b expected %b",
                         c, {cap_o[c], cap_v[c], cap_l[c], cap_r[c]}, exp);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] pat;
        int         hits;
        int         seen;
        l_if.din = 8'h0D; l_if.din_valid = 1'b1;
        @(negedge clk);
        l_if.din_valid = 1'b0;
        for (int c = 1; c <= F + 1; c++) begin
            record(c, 1'b1);
            @(negedge clk);
        end
        pat = 4'b0; hits = 0; seen = 0;
        for (int c = 1; c <= F + 1; c++) begin
            if (c <= F) begin
                n_checks++;
                if ({cap_o[c], cap_v[c]} !== {exp_bit(8'h0D, c, 1'b0), 1'b1}) begin
                    n_fail++;
                    $display("FAIL lsb_first cycle %0d: got out/valid=%b expected %b%b",
                             c, {cap_o[c], cap_v[c]}, exp_bit(8'h0D, c, 1'b0), 1'b1);
                end
            end
            if (cap_v[c]) begin
                pat = {pat[2:0], cap_o[c]};
                seen++;
                if (seen >= 4 && pat == 4'b1011) hits++;
            end
        end
        n_checks++;
        if (hits !== 1) begin
            n_fail++;
            $display("FAIL lsb_detect_1011: got %0d hits expected 1", hits);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] exp;
        m_if.din = 8'hFF; m_if.din_valid = 1'b1;
        @(negedge clk);
        m_if.din_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            record(c, 1'b0);
            n_checks++;
            if ({cap_o[c], cap_v[c], cap_r[c]} !== 3'b110) begin
                n_fail++;
                $display("FAIL pre_reset cycle %0d: got out/valid/ready=%b expected 110",
                         c, {cap_o[c], cap_v[c], cap_r[c]});
            end
            if (c == 3) begin
                reset = 1'b1;
                m_if.din = 8'hAA; m_if.din_valid = 1'b1;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        m_if.din_valid = 1'b0;
        for (int c = 4; c <= F + 2; c++) begin
            record(c, 1'b0);
            @(negedge clk);
        end
        for (int c = 4; c <= F + 2; c++) begin
            n_checks++;
            if ({cap_o[c], cap_v[c], cap_l[c], cap_r[c]} !== 4'b0001) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d: got out/valid/last/ready=%b expected 0001",
                         c, {cap_o[c], cap_v[c], cap_l[c], cap_r[c]});
            end
        end
        m_if.din = 8'h01; m_if.din_valid = 1'b1;
        @(negedge clk);
        m_if.din_valid = 1'b0;
        for (int c = 1; c <= F + 1; c++) begin
            record(c, 1'b0);
            @(negedge clk);
        end
        for (int c = 1; c <= F + 1; c++) begin
            exp = {(c <= F) ? exp_bit(8'h01, c, 1'b1) : 1'b0, c <= F, c == F, c >= F};
            n_checks++;
            if ({cap_o[c], cap_v[c], cap_l[c], cap_r[c]} !== exp) begin
                n_fail++;
                $display("FAIL resend_01 cycle %0d: got out/valid/last/ready=%b expected %b",
                         c, {cap_o[c], cap_v[c], cap_l[c], cap_r[c]}, exp);
            end
        end
    endtask

    task automatic test_din_ignored();
        logic [3:0] exp;
        logic [7:0] w;
        int         k;
        m_if.din = 8'h96; m_if.din_valid = 1'b1;
        @(negedge clk);
        m_if.din_valid = 1'b0;
        for (int c = 1; c <= 2 * F + 1; c++) begin
            record(c, 1'b0);
            if (c == 2) m_if.din = 8'h00;
            if (c == 4) begin
                m_if.din = 8'h3C; m_if.din_valid = 1'b1;
            end
            if (c == F + 1) m_if.din_valid = 1'b0;
            @(negedge clk);
        end
        for (int c = 1; c <= 2 * F + 1; c++) begin
            w = (c <= F) ? 8'h96 : 8'h3C;
            k = (c <= F) ? c : c - F;
            exp = {(c <= 2 * F) ? exp_bit(w, k, 1'b1) : 1'b0, c <= 2 * F,
                   c == F || c == 2 * F, c == F || c >= 2 * F};
            n_checks++;
            if ({cap_o[c], cap_v[c], cap_l[c], cap_r[c]} !== exp) begin
                n_fail++;
                $display("FAIL din_ignored cycle %0d: got out/valid/last/ready=%b expected %b",
                         c, {cap_o[c], cap_v[c], cap_l[c], cap_r[c]}, exp);
            end
        end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        m_if.din = 8'hB4; m_if.din_valid = 1'b1;
        @(negedge clk);
        m_if.din_valid = 1'b0;
        for (int c = 1; c <= F + 1; c++) begin
            record(c, 1'b0);
            @(negedge clk);
        end
        n_checks++;
        if ({cap_o[9], cap_v[9], cap_l[9], cap_r[9]} !== 4'b0111) begin
            n_fail++;
            $display("FAIL parity_b4: got out/valid/last/ready=%b expected 0111",
                     {cap_o[9], cap_v[9], cap_l[9], cap_r[9]});
        end
        n_checks++;
        if ({cap_l[8], cap_r[8], cap_v[10]} !== 3'b000) begin
            n_fail++;
            $display("FAIL parity_b4_edges: got last8/ready8/valid10=%b expected 000",
                     {cap_l[8], cap_r[8], cap_v[10]});
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_lsb_first();
        repeat (2) @(negedge clk);
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        test_din_ignored();
`ifdef SER_PARITY_EN
        repeat (2) @(negedge clk);
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
